lfsr_pixel_streamer: RTL and testbench
======================================

Name: lfsr_pixel_streamer

Overview:
- Downstream consumer of the 16-bit LFSR pattern generator in the grayscale/Sobel test path.
- Takes LFSR words, treats each as an RGB565 pixel and expands it to RGB888.
- Emits one raster frame of IMG_WIDTH x IMG_HEIGHT pixels on a valid/ready stream to the grayscale stage, with frame/line markers.
- Keeps a 16-bit running signature of consumed words for on-chip self-check.

Parameters:
IMG_WIDTH, 16, pixels per line (>=2)
IMG_HEIGHT, 16, lines per frame (>=2)

Ports:
clk_i  input  1  system clock, all state on rising edge
nreset_i  input  1  asynchronous, active-high reset (despite name: 1 = reset)
start_i  input  1  one-cycle pulse, begins a frame from IDLE or DONE
word_i  input  16  LFSR word, RGB565 {R[15:11],G[10:5],B[4:0]}
word_valid_i  input  1  word_i valid this cycle
word_ready_o  output  1  block accepts word_i this cycle
lfsr_done_i  input  1  upstream generator has stopped producing
pix_o  output  24  RGB888 {R,G,B}
pix_valid_o  output  1  pix_o valid
pix_ready_i  input  1  downstream accepts pix_o
sof_o  output  1  qualifies pix_o: first pixel of frame
eol_o  output  1  qualifies pix_o: last pixel of a line
eof_o  output  1  qualifies pix_o: last pixel of frame
busy_o  output  1  state == STREAM
done_o  output  1  state == DONE
underrun_o  output  1  sticky: frame aborted, upstream ran dry
signature_o  output  16  running signature

Behaviour:
- Reset (async, nreset_i=1): state IDLE; all outputs 0; col/row counters, signature, accepted-pixel count = 0.
- States: IDLE -start_i-> STREAM; STREAM -last pixel handshaked-> DONE; STREAM -underrun-> DONE; DONE -start_i-> STREAM.
- start_i in STREAM is ignored.
- On start_i (from IDLE/DONE):
  - clear col, row, signature, underrun_o, pix_valid_o and the input-accepted count.
  - first word may be accepted the cycle after start_i.
- Input handshake: word_ready_o = busy_o && (input count < W*H) && (!pix_valid_o || pix_ready_i).
  - word accepted when word_valid_i && word_ready_o.
- Output register, latency 1: accepted word appears on pix_o with pix_valid_o=1 the next cycle.
- pix_o, sof_o, eol_o, eof_o hold stable while pix_valid_o && !pix_ready_i.
- pix_valid_o clears after handshake unless a new word is accepted the same cycle, giving full throughput of 1 pixel/cycle.
- Expansion: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
- Markers are computed from col/row of the pixel being loaded:
  - sof = (col==0 && row==0)
  - eol = (col==IMG_WIDTH-1)
  - eof = eol && (row==IMG_HEIGHT-1)
- Counters advance on input accept: col wraps to 0 at IMG_WIDTH-1 and increments row; row does not wrap within a frame.
- Signature on input accept: sig <= {sig[14:0],sig[15]} ^ word_i.
  - Held after frame end; cleared only by start_i or reset.
- Frame end: DONE is entered the cycle after the eof pixel handshake. pix_valid_o is 0 in DONE.
- Underrun: in STREAM, lfsr_done_i=1 && word_valid_i=0 && input count < W*H → underrun_o=1 (sticky).
  - Already-buffered pixel is still presented until handshaked.
  - State goes to DONE once the output register is empty.
- Simultaneous word_valid_i and lfsr_done_i: the word is accepted and no underrun is flagged that cycle.
- Reset mid-frame: immediate return to reset values; a partial frame is discarded.

Test Plan:
- Reset → all outputs 0, state IDLE; word_ready_o=0 with word_valid_i=1.
- Expansion, pix_ready_i=1: words 0xF800, 0x07E0, 0x001F, 0x8410 → pix_o 0xFF0000, 0x00FF00, 0x0000FF, 0x848284, each 1 cycle after accept.
- Frame, W=4 H=2, continuous valid/ready:
  - 8 pixels back-to-back; sof only on pixel 0; eol on pixels 3 and 7; eof on pixel 7.
  - done_o=1 the cycle after pixel 7; signature for words 0x0001, 0x0002 first = 0x0001 then 0x0000.
- Backpressure: hold pix_ready_i=0 for 5 cycles mid-line → pix_o/markers stable, word_ready_o=0, no word lost or duplicated; signature equals the unstalled run.
- Underrun: W=4 H=2, lfsr_done_i=1 with word_valid_i=0 after 3 words → underrun_o=1, 3 pixels delivered, then done_o=1; start_i clears underrun_o.
- Reset mid-frame after 5 pixels → outputs 0; new start_i gives sof on the first pixel and a fresh signature.

Source files
------------

// File: rtl/lfsr_pixel_streamer_if.sv
`default_nettype none
// ============================================================================
// lfsr_pixel_streamer_if
// Word-in / pixel-out stream bundle between LFSR source, streamer and sink.
// Revision: 1.0
// ============================================================================
interface lfsr_pixel_streamer_if;
    logic        start_i;
    logic [15:0] word_i;
    logic        word_valid_i;
    logic        word_ready_o;
    logic        lfsr_done_i;
    logic [23:0] pix_o;
    logic        pix_valid_o;
    logic        pix_ready_i;
    logic        sof_o;
    logic        eol_o;
    logic        eof_o;
    logic        busy_o;
    logic        done_o;
    logic        underrun_o;
    logic [15:0] signature_o;

    modport slave (
        input  start_i, word_i, word_valid_i, lfsr_done_i, pix_ready_i,
        output word_ready_o, pix_o, pix_valid_o, sof_o, eol_o, eof_o,
               busy_o, done_o, underrun_o, signature_o
    );

    modport master (
        output start_i, word_i, word_valid_i, lfsr_done_i, pix_ready_i,
        input  word_ready_o, pix_o, pix_valid_o, sof_o, eol_o, eof_o,
               busy_o, done_o, underrun_o, signature_o
    );
endinterface
`default_nettype wire

// File: rtl/lfsr_pixel_streamer.sv
`default_nettype none
// ============================================================================
// lfsr_pixel_streamer
// RGB565 LFSR words -> one RGB888 raster frame with sof/eol/eof and signature.
// Revision: 1.0
// ============================================================================
module lfsr_pixel_streamer #(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16
) (
    input  wire logic             clk_i,
    input  wire logic             nreset_i,
    lfsr_pixel_streamer_if.slave  bus
);
    localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
    localparam int CW    = $clog2(IMG_WIDTH);
    localparam int RW    = $clog2(IMG_HEIGHT + 1);
    localparam int NW    = $clog2(TOTAL + 1);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [NW-1:0] N_TOTAL  = NW'(TOTAL);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          busy;
    logic          done;
    logic          word_ready;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [NW-1:0] in_count;
    logic [23:0]   pix;
    logic          pix_valid;
    logic          sof;
    logic          eol;
    logic          eof;
    logic          underrun;
    logic [15:0]   sig;

    logic          start_go;
    logic          more_words;
    logic          accept;
    logic          out_hs;
    logic          dry;
    logic          eol_ld;
    logic [23:0]   rgb888;

    assign start_go   = bus.start_i && (state != S_STREAM);
    assign more_words = (in_count < N_TOTAL);
    assign accept     = bus.word_valid_i && word_ready;
    assign out_hs     = pix_valid && bus.pix_ready_i;
    // A word arriving together with lfsr_done_i is taken, not counted as a dry cycle.
    assign dry        = busy && bus.lfsr_done_i && !bus.word_valid_i && more_words;
    assign eol_ld     = (col == COL_LAST);

    assign rgb888 = {bus.word_i[15:11], bus.word_i[15:13],
                     bus.word_i[10:5],  bus.word_i[10:9],
                     bus.word_i[4:0],   bus.word_i[4:2]};

    always_ff @(posedge clk_i or posedge nreset_i) begin
        if (nreset_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.start_i) state_nxt = S_STREAM;
            S_STREAM: begin
                if (out_hs && eof) begin
                    state_nxt = S_DONE;
                end else if ((underrun || dry) && (!pix_valid || out_hs)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:   if (bus.start_i) state_nxt = S_STREAM;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state == S_STREAM);
        done       = (state == S_DONE);
        word_ready = busy && more_words && (!pix_valid || bus.pix_ready_i);
    end

    always_ff @(posedge clk_i or posedge nreset_i) begin
        if (nreset_i) begin
            col       <= '0;
            row       <= '0;
            in_count  <= '0;
            pix       <= '0;
            pix_valid <= 1'b0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            eof       <= 1'b0;
            underrun  <= 1'b0;
            sig       <= '0;
        end else if (start_go) begin
            col       <= '0;
            row       <= '0;
            in_count  <= '0;
            pix_valid <= 1'b0;
            underrun  <= 1'b0;
            sig       <= '0;
        end else begin
            if (accept) begin
                pix       <= rgb888;
                pix_valid <= 1'b1;
                sof       <= (col == '0) && (row == '0);
                eol       <= eol_ld;
                eof       <= eol_ld && (row == ROW_LAST);
                sig       <= {sig[14:0], sig[15]} ^ bus.word_i;
                in_count  <= in_count + NW'(1);
                if (eol_ld) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end else if (out_hs) begin
                pix_valid <= 1'b0;
            end
            if (dry) begin
                underrun <= 1'b1;
            end
        end
    end

    assign bus.word_ready_o = word_ready;
    assign bus.pix_o        = pix;
    assign bus.pix_valid_o  = pix_valid;
    assign bus.sof_o        = sof;
    assign bus.eol_o        = eol;
    assign bus.eof_o        = eof;
    assign bus.busy_o       = busy;
    assign bus.done_o       = done;
    assign bus.underrun_o   = underrun;
    assign bus.signature_o  = sig;
endmodule
`default_nettype wire

// File: tb/tb_lfsr_pixel_streamer.sv
`default_nettype none
// ============================================================================
// tb_lfsr_pixel_streamer
// Random-stimulus bench for lfsr_pixel_streamer against a frame-level model.
// Revision: 1.0
// ============================================================================
module tb_lfsr_pixel_streamer;
    localparam int W = 4;
    localparam int H = 2;
    localparam int N = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    logic s_ready;
    logic [26:0] out_pix[$];
    logic [15:0] acc_words[$];

    lfsr_pixel_streamer_if bus();

    lfsr_pixel_streamer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk_i    (clk),
        .nreset_i (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    function automatic logic [23:0] expand(input logic [15:0] w);
        int r, g, b;
        r = (int'(w) >> 11) & 31;
        g = (int'(w) >> 5) & 63;
        b = int'(w) & 31;
        return 24'((((r * 8) + (r / 4)) << 16) | (((g * 4) + (g / 16)) << 8) | ((b * 8) + (b / 4)));
    endfunction

    function automatic logic [26:0] exp_entry(input int idx, input logic [15:0] w);
        logic s, l, f;
        s = (idx == 0);
        l = ((idx % W) == W - 1);
        f = (idx == N - 1);
        return {s, l, f, expand(w)};
    endfunction

    function automatic logic [15:0] sig_model(input logic [15:0] ws[$]);
        int s;
        s = 0;
        foreach (ws[i]) s = (((s * 2) + (s / 32768)) % 65536) ^ int'(ws[i]);
        return 16'(s);
    endfunction

    // Apply inputs at the falling edge, observe handshakes just before the rising edge.
    task automatic cyc(input bit st, input bit wv, input logic [15:0] w, input bit ld, input bit pr);
        bus.start_i      = st;
        bus.word_valid_i = wv;
        bus.word_i       = w;
        bus.lfsr_done_i  = ld;
        bus.pix_ready_i  = pr;
        #1;
        s_ready = bus.word_ready_o;
        if (wv && bus.word_ready_o) acc_words.push_back(w);
        if (bus.pix_valid_o && pr) out_pix.push_back({bus.sof_o, bus.eol_o, bus.eof_o, bus.pix_o});
        @(negedge clk);
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        bus.start_i = 1'b0; bus.word_valid_i = 1'b0; bus.word_i = '0;
        bus.lfsr_done_i = 1'b0; bus.pix_ready_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        acc_words.delete();
        out_pix.delete();
    endtask

    task automatic start_frame;
        acc_words.delete();
        out_pix.delete();
        cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic test_reset;
        bus.start_i = 1'b0; bus.word_valid_i = 1'b1; bus.word_i = 16'hFFFF;
        bus.lfsr_done_i = 1'b0; bus.pix_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({bus.pix_o, bus.pix_valid_o, bus.sof_o, bus.eol_o, bus.eof_o} !== 28'h0) begin
            miscompares++;
            $display("FAIL reset_pix: got %h want %h", {bus.pix_o, bus.pix_valid_o, bus.sof_o, bus.eol_o, bus.eof_o}, 28'h0);
        end
        vectors++;
        if ({bus.busy_o, bus.done_o, bus.underrun_o, bus.signature_o} !== 19'h0) begin
            miscompares++;
            $display("FAIL reset_status: got %h want %h", {bus.busy_o, bus.done_o, bus.underrun_o, bus.signature_o}, 19'h0);
        end
        vectors++;
        if (bus.word_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_word_ready: got %b want 0", bus.word_ready_o);
        end
        rst = 1'b0;
        cyc(1'b0, 1'b1, 16'h1234, 1'b0, 1'b1);
        vectors++;
        if (s_ready !== 1'b0 || acc_words.size() != 0 || bus.busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_no_accept: got ready=%b acc=%0d busy=%b want 0/0/0", s_ready, acc_words.size(), bus.busy_o);
        end
    endtask

    task automatic test_expansion;
        logic [15:0] ws[$];
        apply_reset();
        start_frame();
        ws = '{16'hF800, 16'h07E0, 16'h001F, 16'h8410};
        for (int i = 0; i < 4; i++) ws.push_back(16'($urandom));
        for (int i = 0; i < N; i++) begin
            cyc(1'b0, 1'b1, ws[i], 1'b0, 1'b1);
            vectors++;
            if (s_ready !== 1'b1 || bus.pix_valid_o !== 1'b1 || bus.pix_o !== expand(ws[i])) begin
                miscompares++;
                $display("FAIL expand[%0d]: got rdy=%b v=%b pix=%h want 1/1/%h", i, s_ready, bus.pix_valid_o, bus.pix_o, expand(ws[i]));
            end
        end
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        vectors++;
        if (bus.done_o !== 1'b1 || bus.pix_valid_o !== 1'b0 || bus.signature_o !== sig_model(ws)) begin
            miscompares++;
            $display("FAIL expand_end: got done=%b v=%b sig=%h want 1/0/%h", bus.done_o, bus.pix_valid_o, bus.signature_o, sig_model(ws));
        end
    endtask

    task automatic test_frame;
        logic [15:0] ws[$];
        apply_reset();
        start_frame();
        ws = '{16'h0001, 16'h0002};
        for (int i = 2; i < N; i++) ws.push_back(16'($urandom));
        for (int i = 0; i < N; i++) begin
            // A start pulse mid-stream must not restart the frame.
            cyc(i == 4, 1'b1, ws[i], 1'b0, 1'b1);
            if (i < 2) begin
                vectors++;
                if (bus.signature_o !== ((i == 0) ? 16'h0001 : 16'h0000)) begin
                    miscompares++;
                    $display("FAIL frame_sig[%0d]: got %h want %h", i, bus.signature_o, (i == 0) ? 16'h0001 : 16'h0000);
                end
            end
        end
        vectors++;
        if (acc_words.size() != N || bus.done_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_b2b: got acc=%0d done=%b busy=%b want %0d/0/1", acc_words.size(), bus.done_o, bus.busy_o, N);
        end
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        vectors++;
        if (bus.done_o !== 1'b1 || out_pix.size() != N) begin
            miscompares++;
            $display("FAIL frame_done: got done=%b pix=%0d want 1/%0d", bus.done_o, out_pix.size(), N);
        end
        for (int i = 0; i < out_pix.size() && i < N; i++) begin
            vectors++;
            if (out_pix[i] !== exp_entry(i, ws[i])) begin
                miscompares++;
                $display("FAIL frame_pix[%0d]: got %h want %h", i, out_pix[i], exp_entry(i, ws[i]));
            end
        end
        cyc(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b1);
        vectors++;
        if (bus.signature_o !== sig_model(ws) || s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_hold: got sig=%h rdy=%b want %h/0", bus.signature_o, s_ready, sig_model(ws));
        end
        start_frame();
        vectors++;
        if (bus.busy_o !== 1'b1 || bus.signature_o !== 16'h0) begin
            miscompares++;
            $display("FAIL restart: got busy=%b sig=%h want 1/0000", bus.busy_o, bus.signature_o);
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] ws[$];
        logic [26:0] prev;
        bit prev_stall, stall, pr, wv, pv;
        int idx, n;
        apply_reset();
        start_frame();
        for (int i = 0; i < N; i++) ws.push_back(16'($urandom));
        idx = 0; n = 0; prev_stall = 1'b0; prev = '0;
        while (out_pix.size() < N && n < 200) begin
            if (prev_stall) begin
                vectors++;
                if ({bus.pix_valid_o, bus.sof_o, bus.eol_o, bus.eof_o, bus.pix_o} !== {1'b1, prev}) begin
                    miscompares++;
                    $display("FAIL stall_hold: got %h want %h", {bus.pix_valid_o, bus.sof_o, bus.eol_o, bus.eof_o, bus.pix_o}, {1'b1, prev});
                end
            end
            stall = (n >= 3 && n < 8);
            pr = (n < 3) ? 1'b1 : (stall ? 1'b0 : ($urandom_range(0, 3) != 0));
            wv = (idx < N) && (n < 3 || $urandom_range(0, 3) != 0);
            pv = bus.pix_valid_o;
            prev = {bus.sof_o, bus.eol_o, bus.eof_o, bus.pix_o};
            cyc(1'b0, wv, (idx < N) ? ws[idx] : 16'h0, 1'b0, pr);
            if (stall && pv) begin
                vectors++;
                if (s_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stall_ready: got %b want 0", s_ready);
                end
            end
            prev_stall = pv && !pr;
            idx = acc_words.size();
            n++;
        end
        vectors++;
        if (out_pix.size() != N || bus.done_o !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_count: got pix=%0d done=%b want %0d/1", out_pix.size(), bus.done_o, N);
        end
        for (int i = 0; i < out_pix.size() && i < N; i++) begin
            vectors++;
            if (out_pix[i] !== exp_entry(i, ws[i])) begin
                miscompares++;
                $display("FAIL bp_pix[%0d]: got %h want %h", i, out_pix[i], exp_entry(i, ws[i]));
            end
        end
        vectors++;
        if (bus.signature_o !== sig_model(ws)) begin
            miscompares++;
            $display("FAIL bp_sig: got %h want %h", bus.signature_o, sig_model(ws));
        end
    endtask

    task automatic test_underrun;
        logic [15:0] ws[$];
        int n;
        apply_reset();
        start_frame();
        for (int i = 0; i < 3; i++) ws.push_back(16'($urandom));
        cyc(1'b0, 1'b1, ws[0], 1'b0, 1'b1);
        cyc(1'b0, 1'b1, ws[1], 1'b0, 1'b1);
        cyc(1'b0, 1'b1, ws[2], 1'b1, 1'b1);
        vectors++;
        if (bus.underrun_o !== 1'b0 || acc_words.size() != 3) begin
            miscompares++;
            $display("FAIL ur_simul: got ur=%b acc=%0d want 0/3", bus.underrun_o, acc_words.size());
        end
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        vectors++;
        if (bus.underrun_o !== 1'b1 || bus.pix_valid_o !== 1'b1 || bus.busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL ur_flag: got ur=%b v=%b busy=%b want 1/1/1", bus.underrun_o, bus.pix_valid_o, bus.busy_o);
        end
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        n = 0;
        while (!bus.done_o && n < 10) begin
            cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
            n++;
        end
        vectors++;
        if (bus.done_o !== 1'b1 || out_pix.size() != 3 || bus.pix_valid_o !== 1'b0 || bus.underrun_o !== 1'b1) begin
            miscompares++;
            $display("FAIL ur_done: got done=%b pix=%0d v=%b ur=%b want 1/3/0/1", bus.done_o, out_pix.size(), bus.pix_valid_o, bus.underrun_o);
        end
        for (int i = 0; i < out_pix.size() && i < 3; i++) begin
            vectors++;
            if (out_pix[i] !== exp_entry(i, ws[i])) begin
                miscompares++;
                $display("FAIL ur_pix[%0d]: got %h want %h", i, out_pix[i], exp_entry(i, ws[i]));
            end
        end
        vectors++;
        if (bus.signature_o !== sig_model(ws)) begin
            miscompares++;
            $display("FAIL ur_sig: got %h want %h", bus.signature_o, sig_model(ws));
        end
        start_frame();
        vectors++;
        if (bus.underrun_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.signature_o !== 16'h0) begin
            miscompares++;
            $display("FAIL ur_clear: got ur=%b busy=%b sig=%h want 0/1/0000", bus.underrun_o, bus.busy_o, bus.signature_o);
        end
    endtask

    task automatic test_reset_midframe;
        logic [15:0] ws[$];
        int n;
        apply_reset();
        start_frame();
        n = 0;
        while (out_pix.size() < 5 && n < 20) begin
            cyc(1'b0, 1'b1, 16'($urandom), 1'b0, 1'b1);
            n++;
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.pix_o, bus.pix_valid_o, bus.sof_o, bus.eol_o, bus.eof_o, bus.busy_o, bus.done_o,
             bus.underrun_o, bus.signature_o, bus.word_ready_o} !== 48'h0 || out_pix.size() != 5) begin
            miscompares++;
            $display("FAIL midreset: got %h pix=%0d want 0/5", {bus.pix_o, bus.pix_valid_o, bus.sof_o, bus.eol_o,
                     bus.eof_o, bus.busy_o, bus.done_o, bus.underrun_o, bus.signature_o, bus.word_ready_o}, out_pix.size());
        end
        @(negedge clk);
        rst = 1'b0;
        start_frame();
        for (int i = 0; i < N; i++) ws.push_back(16'($urandom));
        n = 0;
        while (out_pix.size() < N && n < 40) begin
            cyc(1'b0, acc_words.size() < N, ws[acc_words.size() % N], 1'b0, 1'b1);
            n++;
        end
        vectors++;
        if (out_pix.size() != N || bus.signature_o !== sig_model(ws)) begin
            miscompares++;
            $display("FAIL post_reset: got pix=%0d sig=%h want %0d/%h", out_pix.size(), bus.signature_o, N, sig_model(ws));
        end
        for (int i = 0; i < out_pix.size() && i < N; i++) begin
            vectors++;
            if (out_pix[i] !== exp_entry(i, ws[i])) begin
                miscompares++;
                $display("FAIL post_reset_pix[%0d]: got %h want %h", i, out_pix[i], exp_entry(i, ws[i]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_expansion();
        test_frame();
        test_backpressure();
        test_underrun();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
